// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-word instruction fetch FSM feeding a valid/ready instruction register.
// Optional FETCH_INSTR_COUNT_EN adds a 16-bit issued-instruction counter output (instr_count).
`default_nettype none
`timescale 1ns/1ps

module fetch_sequencer #(
  parameter int          DataWidth   = 16,
  parameter int          AddrWidth   = 8,
  parameter int          WordSize    = 1,
  parameter int unsigned ResetVector = 0
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Halt,
  output logic [AddrWidth-1:0]          mem_addr,
  output logic                          mem_rd,
  input  logic [DataWidth-1:0]          mem_data,
  output logic [DataWidth*WordSize-1:0] ir,
  output logic                          ir_valid,
  input  logic                          ir_ready,
  input  logic                          pc_ld,
  input  logic [AddrWidth-1:0]          pc_ld_addr,
  output logic [AddrWidth-1:0]          pc_out,
  output logic                          halted
`ifdef FETCH_INSTR_COUNT_EN
  ,
  output logic [15:0]                   instr_count
`endif
);

  localparam int                   IdxW       = (WordSize > 1) ? $clog2(WordSize) : 1;
  localparam logic [AddrWidth-1:0] c_RESET_PC = AddrWidth'(ResetVector);
  localparam logic [IdxW-1:0]      c_LAST_IDX = IdxW'(WordSize - 1);

  typedef enum logic [2:0] {
    S_Reset,
    S_FetchPCtoMEM,
    S_FetchMEMtoIR,
    S_Issue,
    S_Halt
  } state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [AddrWidth-1:0]            r_pc;
  logic [DataWidth*WordSize-1:0]   r_ir;
  logic [IdxW-1:0]                 r_word_idx;
  logic                            w_handshake;
  logic                            w_pc_load;

  assign w_handshake = (r_state == S_Issue) && ir_ready;
  // PC load is only legal when no fetch is in flight: at issue or while parked.
  assign w_pc_load   = pc_ld && (w_handshake || (r_state == S_Halt));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_Reset;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    mem_rd   = 1'b0;
    ir_valid = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_Reset:        w_next = S_FetchPCtoMEM;
      S_FetchPCtoMEM: begin
        mem_rd = 1'b1;
        w_next = S_FetchMEMtoIR;
      end
      S_FetchMEMtoIR: w_next = (r_word_idx == c_LAST_IDX) ? S_Issue : S_FetchPCtoMEM;
      S_Issue: begin
        ir_valid = 1'b1;
        if (ir_ready) begin
          w_next = Halt ? S_Halt : S_FetchPCtoMEM;
        end
      end
      S_Halt: begin
        halted = 1'b1;
        if (!Halt) begin
          w_next = S_FetchPCtoMEM;
        end
      end
      default:        w_next = S_Reset;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc       <= c_RESET_PC;
      r_ir       <= '0;
      r_word_idx <= '0;
    end else begin
      if (r_state == S_FetchMEMtoIR) begin
        for (int k = 0; k < WordSize; k++) begin
          if (r_word_idx == IdxW'(k)) begin
            r_ir[k*DataWidth +: DataWidth] <= mem_data;
          end
        end
        r_pc       <= r_pc + 1'b1;
        r_word_idx <= (r_word_idx == c_LAST_IDX) ? '0 : r_word_idx + 1'b1;
      end else if (w_pc_load) begin
        r_pc <= pc_ld_addr;
      end
    end
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_instr_count <= '0;
    end else if (w_handshake) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign instr_count = r_instr_count;
`endif

  assign mem_addr = r_pc;
  assign pc_out   = r_pc;
  assign ir       = r_ir;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks on a WordSize=1 and a WordSize=2 fetch_sequencer instance.
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_sequencer;

  logic        Clk;
  logic        rst;
  int          n_pass;
  int          n_total;

  // instance A: WordSize=1
  logic        haltA, readyA, pc_ldA;
  logic [7:0]  ldaddrA, addrA, pcA;
  logic        rdA, vldA, haltedA;
  logic [15:0] dataA, irA;
  logic [15:0] memA [256];

  // instance B: WordSize=2
  logic        haltB, readyB, pc_ldB;
  logic [7:0]  ldaddrB, addrB, pcB;
  logic        rdB, vldB, haltedB;
  logic [15:0] dataB;
  logic [31:0] irB;
  logic [15:0] memB [256];

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] cntA, cntB;
`endif

  fetch_sequencer #(.DataWidth(16), .AddrWidth(8), .WordSize(1), .ResetVector(0)) u_dut_a (
    .Clk(Clk), .Reset(rst), .Halt(haltA),
    .mem_addr(addrA), .mem_rd(rdA), .mem_data(dataA),
    .ir(irA), .ir_valid(vldA), .ir_ready(readyA),
    .pc_ld(pc_ldA), .pc_ld_addr(ldaddrA), .pc_out(pcA), .halted(haltedA)
`ifdef FETCH_INSTR_COUNT_EN
    , .instr_count(cntA)
`endif
  );

  fetch_sequencer #(.DataWidth(16), .AddrWidth(8), .WordSize(2), .ResetVector(0)) u_dut_b (
    .Clk(Clk), .Reset(rst), .Halt(haltB),
    .mem_addr(addrB), .mem_rd(rdB), .mem_data(dataB),
    .ir(irB), .ir_valid(vldB), .ir_ready(readyB),
    .pc_ld(pc_ldB), .pc_ld_addr(ldaddrB), .pc_out(pcB), .halted(haltedB)
`ifdef FETCH_INSTR_COUNT_EN
    , .instr_count(cntB)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // synchronous-read memories: data appears the cycle after mem_rd
  always @(posedge Clk) begin
    if (rdA) dataA <= memA[addrA];
    if (rdB) dataB <= memB[addrB];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // advance B until ir_valid, counting cycles and read strobes along the way
  task automatic wait_issue(output int cycles, output int rds);
    cycles = 0;
    rds    = 0;
    while (!vldB && cycles < 50) begin
      if (rdB) rds++;
      tick();
      cycles++;
    end
  endtask

  int cyc, rds;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    haltA = 1'b0; readyA = 1'b1; pc_ldA = 1'b0; ldaddrA = 8'h00;
    haltB = 1'b0; readyB = 1'b0; pc_ldB = 1'b0; ldaddrB = 8'h00;
    for (int i = 0; i < 256; i++) begin
      memA[i] = 16'h0000;
      memB[i] = 16'h0000;
    end
    memA[0]     = 16'h1234;
    memB[0]     = 16'hAAAA;
    memB[1]     = 16'h5555;
    memB[2]     = 16'h1111;
    memB[3]     = 16'h2222;
    memB[8'h40] = 16'h4040;
    memB[8'h41] = 16'h4141;
    memB[8'hFF] = 16'hBEEF;

    tick();
    tick();
    check("rst_validB", vldB, 0);
    check("rst_rdB", rdB, 0);
    check("rst_haltedB", haltedB, 0);
    check("rst_pcB", pcB, 0);
    check("rst_irB", irB, 0);
    check("rst_irA", irA, 0);
`ifdef FETCH_INSTR_COUNT_EN
    check("rst_cntB", cntB, 0);
`endif

    rst = 1'b0;
    check("c1_rdA", rdA, 0);
    tick();
    check("c2_rdA", rdA, 1);
    check("c2_addrA", addrA, 8'h00);
    check("c2_rdB", rdB, 1);
    tick();
    check("c3_validA", vldA, 0);
    check("c3_rdB", rdB, 0);
    tick();
    check("c4_validA", vldA, 1);
    check("c4_irA", irA, 16'h1234);
    check("c4_pcA", pcA, 8'h01);
    check("c4_rdB", rdB, 1);
    check("c4_addrB", addrB, 8'h01);
    tick();
    check("c5_rdB", rdB, 0);
    check("c5_validB", vldB, 0);
    tick();
    check("c6_validB", vldB, 1);
    check("c6_irB", irB, 32'h5555AAAA);
    check("c6_pcB", pcB, 8'h02);

    // stall: ir_ready low, stray pc_ld must be ignored
    pc_ldB = 1'b1; ldaddrB = 8'h77;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", vldB, 1);
      check("stall_ir", irB, 32'h5555AAAA);
      check("stall_rd", rdB, 0);
      check("stall_pc", pcB, 8'h02);
      tick();
    end
    pc_ldB = 1'b0;
    check("stall_end_valid", vldB, 1);
    readyB = 1'b1;
    tick();
    readyB = 1'b0;
    check("accept_rd", rdB, 1);
    check("accept_addr", addrB, 8'h02);
    wait_issue(cyc, rds);
    check("i2_cycles", cyc, 4);
    check("i2_rds", rds, 2);
    check("i2_ir", irB, 32'h22221111);
    check("i2_pc", pcB, 8'h04);

    // halt and pc load on the same handshake
    haltB = 1'b1; pc_ldB = 1'b1; ldaddrB = 8'h40; readyB = 1'b1;
    tick();
    pc_ldB = 1'b0; readyB = 1'b0;
    check("halt_halted", haltedB, 1);
    check("halt_pc", pcB, 8'h40);
    check("halt_rd", rdB, 0);
    check("halt_valid", vldB, 0);
`ifdef FETCH_INSTR_COUNT_EN
    check("halt_cntB", cntB, 2);
`endif
    tick();
    check("halt_hold", haltedB, 1);
    haltB = 1'b0;
    tick();
    check("resume_halted", haltedB, 0);
    check("resume_rd", rdB, 1);
    check("resume_addr", addrB, 8'h40);
    wait_issue(cyc, rds);
    check("i3_cycles", cyc, 4);
    check("i3_ir", irB, 32'h41414040);
    check("i3_pc", pcB, 8'h42);

    // PC wrap across an instruction
    pc_ldB = 1'b1; ldaddrB = 8'hFF; readyB = 1'b1;
    tick();
    pc_ldB = 1'b0; readyB = 1'b0;
    check("wrap_addr", addrB, 8'hFF);
    wait_issue(cyc, rds);
    check("wrap_rds", rds, 2);
    check("wrap_ir", irB, 32'hAAAABEEF);
    check("wrap_pc", pcB, 8'h01);

    // reset in the second word's MEMtoIR cycle
    readyB = 1'b1;
    tick();
    readyB = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_rd", rdB, 0);
    check("pre_rst_pc", pcB, 8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_pc", pcB, 8'h00);
    check("midrst_ir", irB, 0);
    check("midrst_valid", vldB, 0);
`ifdef FETCH_INSTR_COUNT_EN
    check("midrst_cntB", cntB, 0);
`endif
    wait_issue(cyc, rds);
    check("post_rst_cycles", cyc, 5);
    check("post_rst_ir", irB, 32'h5555AAAA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
